shared_bank_reallocator: RTL and testbench

//  Per-bank owner controller for the DynVC router's shared input-VC memory banks; one instance per bank.

---
 rtl/shared_bank_reallocator_pkg.sv | 18 +
 rtl/shared_bank_rr_pick.sv | 28 ++
 rtl/shared_bank_reallocator.sv | 187 ++++++++++++++++++
 tb/tb_shared_bank_reallocator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_bank_reallocator_pkg.sv
// Shared types and helpers for the shared-bank owner controller.
package shared_bank_reallocator_pkg;

   typedef enum logic [1:0] {
      StEnable = 2'd0,
      StDrain  = 2'd1,
      StSwitch = 2'd2
   } state_e;

   // LSB of this bank's VC slice within one port's port-major VC group.
   function automatic int unsigned bank_slice_lsb(input int unsigned port,
                                                  input int unsigned n_vcs,
                                                  input int unsigned bank,
                                                  input int unsigned vcs_per_bank);
      return port * n_vcs + bank * vcs_per_bank;
   endfunction

endpackage

// File: rtl/shared_bank_rr_pick.sv
// Combinational cyclic picker: first requester at or after the one-hot start pointer.
module shared_bank_rr_pick #(
   parameter int unsigned num_req = 5
) (
   input  logic [num_req-1:0] i_req,
   input  logic [num_req-1:0] i_start,
   output logic [num_req-1:0] o_winner,
   output logic               o_any_valid
);

   logic w_found;

   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      for (int unsigned off = 0; off < num_req; off++) begin
         for (int unsigned s = 0; s < num_req; s++) begin
            if (!w_found && i_start[s] && i_req[(s + off) % num_req]) begin
               o_winner[(s + off) % num_req] = 1'b1;
               w_found = 1'b1;
            end
         end
      end
   end

   assign o_any_valid = |i_req;

endmodule

// File: rtl/shared_bank_reallocator.sv
// Per-bank shared-VC owner controller: congestion detect, drain, round-robin owner switch.
// Optional drain timeout enabled by defining DRAIN_TIMEOUT_EN.
module shared_bank_reallocator
   import shared_bank_reallocator_pkg::*;
#(
   parameter int unsigned num_vcs              = 4,
   parameter int unsigned num_ports            = 5,
   parameter int unsigned bank_id              = 0,
   parameter int unsigned num_vcs_per_bank     = 2,
   parameter int unsigned counter_width        = 4,
   parameter int unsigned congestion_threshold = 15,
   parameter int unsigned reset_owner          = 0,
   parameter int unsigned drain_timeout        = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [num_ports*num_vcs-1:0]   allocated_ip_ivc,
   input  logic [num_ports*num_vcs-1:0]   allocated_ip_shared_ivc,
   input  logic [num_vcs_per_bank-1:0]    shared_ivc_empty,
   output logic                           ready_for_allocation,
   output logic [0:num_ports-1]           memory_bank_grant_out,
   output logic                           realloc_pulse_out,
   output logic                           drain_abort_out
);

   localparam logic [counter_width-1:0] CntMax     = '1;
   localparam logic [counter_width-1:0] Thr        = counter_width'(congestion_threshold);
   localparam logic [num_ports-1:0]     ResetGrant = num_ports'(1) << reset_owner;

   if (reset_owner >= num_ports) begin : g_bad_owner
      $error("reset_owner must be below num_ports");
   end
   if (congestion_threshold < 1 || congestion_threshold >= (1 << counter_width)) begin : g_bad_thr
      $error("congestion_threshold out of range");
   end
   if (drain_timeout < 1) begin : g_bad_timeout
      $error("drain_timeout must be at least 1");
   end

   logic [num_ports-1:0]     w_busy;
   logic [num_ports-1:0]     w_shared_busy;
   logic                     w_drained;
   logic [counter_width-1:0] r_cnt [num_ports];
   logic [num_ports-1:0]     r_cong;
   state_e                   r_state;
   state_e                   w_state_d;
   logic [num_ports-1:0]     r_grant;
   logic [num_ports-1:0]     w_grant_d;
   logic [num_ports-1:0]     r_pending;
   logic [num_ports-1:0]     w_pending_d;
   logic [num_ports-1:0]     w_req;
   logic [num_ports-1:0]     w_start;
   logic [num_ports-1:0]     w_pick;
   logic                     w_pick_valid;
   logic                     w_owner_cong;
   logic                     w_abort;

   always_comb begin
      w_busy        = '0;
      w_shared_busy = '0;
      for (int unsigned p = 0; p < num_ports; p++) begin
         w_busy[p] = &allocated_ip_ivc[bank_slice_lsb(p, num_vcs, bank_id, num_vcs_per_bank)
                                       +: num_vcs_per_bank];
         w_shared_busy[p] =
            |allocated_ip_shared_ivc[bank_slice_lsb(p, num_vcs, bank_id, num_vcs_per_bank)
                                     +: num_vcs_per_bank];
      end
   end

   assign w_drained = ~|w_shared_busy & (&shared_ivc_empty);

   // Flag tracks the count before this cycle's increment, so it lags the counter by one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned p = 0; p < num_ports; p++) begin
            r_cnt[p] <= '0;
         end
         r_cong <= '0;
      end else begin
         for (int unsigned p = 0; p < num_ports; p++) begin
            if (w_busy[p]) begin
               if (r_cnt[p] != CntMax) begin
                  r_cnt[p] <= r_cnt[p] + 1'b1;
               end
               r_cong[p] <= (r_cnt[p] >= Thr);
            end else begin
               r_cnt[p]  <= '0;
               r_cong[p] <= 1'b0;
            end
         end
      end
   end

   // Scan starts one port past the current owner.
   always_comb begin
      w_start = '0;
      for (int unsigned p = 0; p < num_ports; p++) begin
         w_start[(p + 1) % num_ports] = r_grant[p];
      end
   end

   assign w_req        = r_cong & ~r_grant;
   assign w_owner_cong = |(r_cong & r_grant);

   shared_bank_rr_pick #(
      .num_req (num_ports)
   ) u_rr_pick (
      .i_req       (w_req),
      .i_start     (w_start),
      .o_winner    (w_pick),
      .o_any_valid (w_pick_valid)
   );

`ifdef DRAIN_TIMEOUT_EN
   localparam int unsigned      DcntW    = $clog2(drain_timeout + 1);
   localparam logic [DcntW-1:0] DcntLast = DcntW'(drain_timeout - 1);

   logic [DcntW-1:0] r_dcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dcnt <= '0;
      end else if (r_state != StDrain) begin
         r_dcnt <= '0;
      end else begin
         r_dcnt <= r_dcnt + 1'b1;
      end
   end
`endif

   always_comb begin
      w_state_d   = r_state;
      w_grant_d   = r_grant;
      w_pending_d = r_pending;
      w_abort     = 1'b0;
      case (r_state)
         StEnable: begin
            if (!w_owner_cong && w_pick_valid) begin
               w_pending_d = w_pick;
               w_state_d   = StDrain;
            end
         end
         StDrain: begin
            if (w_drained) begin
               w_state_d = StSwitch;
            end
`ifdef DRAIN_TIMEOUT_EN
            else if (r_dcnt == DcntLast) begin
               w_state_d = StEnable;
               w_abort   = 1'b1;
            end
`endif
         end
         StSwitch: begin
            w_grant_d = r_pending;
            w_state_d = StEnable;
         end
         default: w_state_d = StEnable;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StEnable;
         r_grant   <= ResetGrant;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_d;
         r_grant   <= w_grant_d;
         r_pending <= w_pending_d;
      end
   end

   assign ready_for_allocation = (r_state == StEnable);
   assign realloc_pulse_out    = (r_state == StSwitch);

`ifdef DRAIN_TIMEOUT_EN
   assign drain_abort_out = w_abort;
`else
   assign drain_abort_out = 1'b0;
`endif

   for (genvar p = 0; p < num_ports; p++) begin : g_grant_out
      assign memory_bank_grant_out[p] = r_grant[p];
   end

endmodule

// File: tb/tb_shared_bank_reallocator.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_shared_bank_reallocator;

   localparam int NP   = 5;
   localparam int NV   = 4;
   localparam int VPB  = 2;
   localparam int BID  = 0;
   localparam int THR  = 15;
   localparam int TO   = 8;
   localparam int ROWN = 0;
   localparam int AW   = NP * NV;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   alloc;
   logic [AW-1:0]   shalloc;
   logic [VPB-1:0]  empty;
   logic            ready;
   logic [0:NP-1]   grant;
   logic            pulse;
   logic            abort_o;

   always #5 clk = ~clk;

   shared_bank_reallocator #(
      .num_vcs              (NV),
      .num_ports            (NP),
      .bank_id              (BID),
      .num_vcs_per_bank     (VPB),
      .counter_width        (4),
      .congestion_threshold (THR),
      .reset_owner          (ROWN),
      .drain_timeout        (TO)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .allocated_ip_ivc        (alloc),
      .allocated_ip_shared_ivc (shalloc),
      .shared_ivc_empty        (empty),
      .ready_for_allocation    (ready),
      .memory_bank_grant_out   (grant),
      .realloc_pulse_out       (pulse),
      .drain_abort_out         (abort_o)
   );

   typedef struct packed {
      logic          ready;
      logic          pulse;
      logic          abrt;
      logic [NP-1:0] grant;  // bit p = port p
   } obs_t;

   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 = allocating, 1 = draining, 2 = switching.
   int m_mode;
   int m_owner;
   int m_pend;
   int m_dcnt;
   int m_run [NP];
   bit m_cong [NP];

   function automatic bit port_busy(input int p);
      logic [VPB-1:0] s;
      s = alloc[p*NV + BID*VPB +: VPB];
      return &s;
   endfunction

   function automatic bit drained();
      logic [VPB-1:0] s;
      for (int p = 0; p < NP; p++) begin
         s = shalloc[p*NV + BID*VPB +: VPB];
         if (s != '0) return 1'b0;
      end
      return &empty;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_owner = ROWN;
      m_pend  = 0;
      m_dcnt  = 0;
      for (int p = 0; p < NP; p++) begin
         m_run[p]  = 0;
         m_cong[p] = 1'b0;
      end
   endtask

   // Advance the model over one clock edge using the inputs held during the cycle before it.
   task automatic model_edge();
      if (reset) begin
         model_reset();
         return;
      end
      case (m_mode)
         0: begin
            if (!m_cong[m_owner]) begin
               for (int k = 1; k < NP; k++) begin
                  if (m_cong[(m_owner + k) % NP]) begin
                     m_pend = (m_owner + k) % NP;
                     m_mode = 1;
                     m_dcnt = 0;
                     break;
                  end
               end
            end
         end
         1: begin
            if (drained()) m_mode = 2;
`ifdef DRAIN_TIMEOUT_EN
            else if (m_dcnt == TO - 1) m_mode = 0;
`endif
            else m_dcnt++;
         end
         default: begin
            m_owner = m_pend;
            m_mode  = 0;
         end
      endcase
      for (int p = 0; p < NP; p++) begin
         if (port_busy(p)) begin
            m_cong[p] = (m_run[p] >= THR);
            m_run[p]++;
         end else begin
            m_cong[p] = 1'b0;
            m_run[p]  = 0;
         end
      end
   endtask

   function automatic obs_t expect_now();
      obs_t e;
      e       = '0;
      e.ready = (m_mode == 0);
      e.pulse = (m_mode == 2);
`ifdef DRAIN_TIMEOUT_EN
      e.abrt  = (m_mode == 1) && (m_dcnt == TO - 1) && !drained();
`endif
      e.grant = NP'(1) << m_owner;
      return e;
   endfunction

   task automatic apply(input logic [NP-1:0] busy, input logic [NP-1:0] shp,
                        input logic [VPB-1:0] emp, input bit rst_in);
      logic [VPB-1:0] s;
      @(posedge clk);
      #1;
      model_edge();
      reset   = rst_in;
      alloc   = AW'($urandom);
      shalloc = AW'($urandom);
      for (int p = 0; p < NP; p++) begin
         if (busy[p]) begin
            s = '1;
         end else begin
            s = VPB'($urandom);
            if (&s) s[0] = 1'b0;
         end
         alloc[p*NV + BID*VPB +: VPB] = s;
         if (shp[p]) begin
            s = VPB'($urandom);
            if (s == '0) s[1] = 1'b1;
         end else begin
            s = '0;
         end
         shalloc[p*NV + BID*VPB +: VPB] = s;
      end
      empty = emp;
      if (rst_in) model_reset();
      sb.push_back(expect_now());
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            obs_t e;
            obs_t a;
            e       = sb.pop_front();
            a.ready = ready;
            a.pulse = pulse;
            a.abrt  = abort_o;
            for (int p = 0; p < NP; p++) a.grant[p] = grant[p];
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle t=%0t got ready=%b pulse=%b abort=%b grant(p0..p4)=%b%b%b%b%b expected ready=%b pulse=%b abort=%b grant(p0..p4)=%b%b%b%b%b",
                        $time, a.ready, a.pulse, a.abrt,
                        a.grant[0], a.grant[1], a.grant[2], a.grant[3], a.grant[4],
                        e.ready, e.pulse, e.abrt,
                        e.grant[0], e.grant[1], e.grant[2], e.grant[3], e.grant[4]);
            end
         end
      end
   end

   initial begin : stimulus
      logic [NP-1:0]  rb;
      logic [NP-1:0]  rs;
      logic [VPB-1:0] re;
      bit             rr;
      int             idx;

      reset   = 1'b1;
      alloc   = '0;
      shalloc = '0;
      empty   = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_grant_port0", 32'(grant[0]), 32'd1);
      chk("reset_grant_others", 32'({grant[1], grant[2], grant[3], grant[4]}), 32'd0);
      chk("reset_pulses", 32'({pulse, abort_o}), 32'd0);

      // Idle: owner held.
      repeat (100) apply('0, '0, '1, 1'b0);
      // Port 2 congested, nothing to drain.
      repeat (16) apply(5'b00100, '0, '1, 1'b0);
      repeat (8) apply('0, '0, '1, 1'b0);
      // Owner 2; ports 1 and 4 congested together.
      repeat (18) apply(5'b10010, '0, '1, 1'b0);
      repeat (8) apply('0, '0, '1, 1'b0);
      // Port 0 congested while port 1 holds a shared VC, then buffers slow to empty.
      repeat (16) apply(5'b00001, 5'b00010, '1, 1'b0);
      repeat (10) apply('0, 5'b00010, 2'b01, 1'b0);
      repeat (3) apply('0, '0, 2'b10, 1'b0);
      repeat (6) apply('0, '0, '1, 1'b0);
      // Shared VC held long: timeout path if enabled, otherwise indefinite drain.
      repeat (16) apply(5'b00100, 5'b01000, '1, 1'b0);
      repeat (30) apply('0, 5'b01000, '1, 1'b0);
      repeat (4) apply('0, '0, '1, 1'b0);
      // Reset in the middle of a drain.
      repeat (16) apply(5'b01000, 5'b00001, '1, 1'b0);
      repeat (3) apply('0, 5'b00001, '1, 1'b0);
      apply('0, 5'b00001, '1, 1'b1);
      repeat (5) apply('0, '0, '1, 1'b0);

      // Random traffic with long busy runs.
      rb = '0;
      rs = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 19) == 0) rb[p] = ~rb[p];
         end
         if ($urandom_range(0, 9) == 0) begin
            idx     = $urandom_range(0, NP - 1);
            rs[idx] = ~rs[idx];
         end
         re = ($urandom_range(0, 3) == 0) ? VPB'($urandom) : '1;
         rr = ($urandom_range(0, 599) == 0);
         apply(rb, rs, re, rr);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
